// File: rtl/led_animation.sv
// Heartbeat LED pattern lookup: one-cycle registered read of an 8-entry frame table plus a frame-change pulse.
// Optional macro LED_ANIMATION_LOAD_EN makes the table writable through the wr_* port group.
module led_animation #(
    parameter bit INVERT = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [2:0] address_i,
`ifdef LED_ANIMATION_LOAD_EN
    input  logic       wr_en_i,
    input  logic [2:0] wr_addr_i,
    input  logic [7:0] wr_data_i,
`endif
    output logic [7:0] db_entry_o,
    output logic       frame_changed_o
);

    localparam logic [7:0] INV_MASK = INVERT ? 8'hFF : 8'h00;

    function automatic logic [7:0] default_entry(input logic [2:0] idx);
        logic [7:0] val;
        case (idx)
            3'd0:    val = 8'h18;
            3'd1:    val = 8'h3C;
            3'd2:    val = 8'h7E;
            3'd3:    val = 8'hFF;
            3'd4:    val = 8'hFF;
            3'd5:    val = 8'h7E;
            3'd6:    val = 8'h3C;
            default: val = 8'h18;
        endcase
        return val;
    endfunction

    logic [7:0] lut_rd;

`ifdef LED_ANIMATION_LOAD_EN
    logic [7:0] lut_q [8];

    // The read below uses the pre-edge contents, so a same-entry write shows up one read later.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 8; i++) begin
                lut_q[i] <= default_entry(3'(i));
            end
        end else if (wr_en_i) begin
            lut_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign lut_rd = lut_q[address_i];
`else
    assign lut_rd = default_entry(address_i);
`endif

    logic [7:0] db_entry_q, db_entry_d;
    logic       frame_changed_q, frame_changed_d;
    logic [2:0] last_addr_q, last_addr_d;

    always_comb begin
        db_entry_d      = lut_rd ^ INV_MASK;
        frame_changed_d = (address_i != last_addr_q);
        last_addr_d     = address_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            db_entry_q      <= 8'h18 ^ INV_MASK;
            frame_changed_q <= 1'b0;
            last_addr_q     <= 3'd0;
        end else begin
            db_entry_q      <= db_entry_d;
            frame_changed_q <= frame_changed_d;
            last_addr_q     <= last_addr_d;
        end
    end

    assign db_entry_o      = db_entry_q;
    assign frame_changed_o = frame_changed_q;

endmodule

// File: tb/tb_led_animation.sv
// Directed bench for led_animation: vector table for stepping/hold/wrap, plus hand sequences for reset and table writes.
module tb_led_animation;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] address = 3'd0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] db_pos, db_neg;
    logic       fc_pos, fc_neg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    led_animation #(.INVERT(1'b0)) u_pos (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .address_i       (address),
`ifdef LED_ANIMATION_LOAD_EN
        .wr_en_i         (wr_en),
        .wr_addr_i       (wr_addr),
        .wr_data_i       (wr_data),
`endif
        .db_entry_o      (db_pos),
        .frame_changed_o (fc_pos)
    );

    led_animation #(.INVERT(1'b1)) u_neg (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .address_i       (address),
`ifdef LED_ANIMATION_LOAD_EN
        .wr_en_i         (wr_en),
        .wr_addr_i       (wr_addr),
        .wr_data_i       (wr_data),
`endif
        .db_entry_o      (db_neg),
        .frame_changed_o (fc_neg)
    );

    typedef struct {
        logic [2:0] addr;
        logic [7:0] exp_db;
        logic       exp_fc;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input logic [7:0] exp_db, input logic exp_fc);
        check({name, " db"}, db_pos, exp_db);
        check({name, " db_inv"}, db_neg, exp_db ^ 8'hFF);
        check({name, " fc"}, {7'd0, fc_pos}, {7'd0, exp_fc});
        check({name, " fc_inv"}, {7'd0, fc_neg}, {7'd0, exp_fc});
    endtask

    task automatic step(input logic [2:0] a);
        address = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{3'd0, 8'h18, 1'b0};
        vecs[1]  = '{3'd1, 8'h3C, 1'b1};
        vecs[2]  = '{3'd2, 8'h7E, 1'b1};
        vecs[3]  = '{3'd3, 8'hFF, 1'b1};
        vecs[4]  = '{3'd4, 8'hFF, 1'b1};
        vecs[5]  = '{3'd5, 8'h7E, 1'b1};
        vecs[6]  = '{3'd6, 8'h3C, 1'b1};
        vecs[7]  = '{3'd7, 8'h18, 1'b1};
        vecs[8]  = '{3'd0, 8'h18, 1'b1};
        vecs[9]  = '{3'd3, 8'hFF, 1'b1};
        vecs[10] = '{3'd3, 8'hFF, 1'b0};
        vecs[11] = '{3'd3, 8'hFF, 1'b0};
        vecs[12] = '{3'd3, 8'hFF, 1'b0};
        vecs[13] = '{3'd3, 8'hFF, 1'b0};
        vecs[14] = '{3'd5, 8'h7E, 1'b1};
        vecs[15] = '{3'd5, 8'h7E, 1'b0};
        vecs[16] = '{3'd1, 8'h3C, 1'b1};
        vecs[17] = '{3'd6, 8'h3C, 1'b1};

        address = 3'd5;
        #12;
        check_all("reset", 8'h18, 1'b0);
        address = 3'd0;
        #10;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].addr);
            check_all($sformatf("vec%0d", i), vecs[i].exp_db, vecs[i].exp_fc);
        end

        // asynchronous reset between edges while a change pulse is high
        step(3'd2);
        check_all("pre_rst", 8'h7E, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 8'h18, 1'b0);
        address = 3'd4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("first_after_rst", 8'hFF, 1'b1);
        step(3'd4);
        check_all("hold_after_rst", 8'hFF, 1'b0);

`ifdef LED_ANIMATION_LOAD_EN
        step(3'd2);
        check_all("ld_pre", 8'h7E, 1'b1);
        wr_en = 1'b1;
        wr_addr = 3'd2;
        wr_data = 8'hA5;
        step(3'd2);
        check_all("ld_same_edge", 8'h7E, 1'b0);
        wr_addr = 3'd5;
        wr_data = 8'h81;
        step(3'd2);
        check_all("ld_next", 8'hA5, 1'b0);
        wr_en = 1'b0;
        step(3'd5);
        check_all("ld_other", 8'h81, 1'b1);
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        step(3'd2);
        check_all("ld_restored2", 8'h7E, 1'b1);
        step(3'd5);
        check_all("ld_restored5", 8'h7E, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
